if_fetch_unit: RTL and testbench
================================

// Module: if_fetch_unit
// PURPOSE
//  Fetch stage of the P7 pipeline and producer side of the F/D register: owns the PC.
//  Drives instruction-memory address; forwards pc/instr/excCode/delaySlot/new_instr into F/D.
//  Obeys the same halt (stall) and req (exception flush) controls as the F/D register.
//  Redirects on branch/jump from D, on eret to EPC, and on exception to the handler.
// PARAMETERS
//  RESET_PC    32'h0000_3000  PC value on reset
//  HANDLER_PC  32'h0000_4180  exception handler entry
//  IM_BASE     32'h0000_3000  lowest legal fetch address
//  IM_LIMIT    32'h0000_6FFC  highest legal fetch address (inclusive)
//  EXC_ADEL    5'd4           excCode for illegal fetch address
// PORTS
//  clk          in   1   clock, rising edge
//  reset        in   1   asynchronous, active-high
//  halt         in   1   stall from hazard unit; hold PC
//  req          in   1   exception request from CP0; redirect to HANDLER_PC
//  d_npc_sel    in   1   branch taken / jump in D
//  d_npc        in   32  branch/jump target from D
//  d_is_jump    in   1   D holds any branch/jump (taken or not)
//  d_eret       in   1   D holds eret
//  epc          in   32  EPC from CP0 (already forwarded)
//  i_inst_rdata in   32  instruction memory read data (combinational in address)
//  i_inst_addr  out  32  instruction memory address
//  f_pc         out  32  PC of fetched instruction
//  f_instr      out  32  fetched instruction (0 when killed or faulting)
//  f_new_instr  out  1   1 = real instruction, 0 = bubble
//  f_excCode    out  5   0 = none, EXC_ADEL = bad fetch address
//  f_delaySlot  out  1   fetched instruction is in a branch delay slot
// BEHAVIOUR
//  - State: 32-bit pc register, async reset to RESET_PC; all outputs combinational from pc/inputs.
//  - Reset values: i_inst_addr=f_pc=RESET_PC, f_excCode=0, f_delaySlot=d_is_jump (0 post-reset).
//  - Next pc, priority high->low, one update per rising edge:
//      req -> HANDLER_PC; halt -> pc; d_eret -> epc; d_npc_sel -> d_npc; else pc+4 (mod 2^32).
//  - req beats halt and eret in the same cycle; halt beats eret/branch (redirect retried next cycle).
//  - i_inst_addr = f_pc = pc, always, including stalled and faulting cycles.
//  - Address fault: pc[1:0]!=0, pc<IM_BASE, or pc>IM_LIMIT ->
//      f_excCode=EXC_ADEL, f_instr=0, f_new_instr=1 (fault rides to CP0 with this pc).
//  - Eret kill: d_eret=1 -> F instruction is not a delay slot; f_instr=0, f_new_instr=0,
//      f_excCode=0, f_delaySlot=0 (independent of halt; bubble is held, not issued, while halted).
//  - Otherwise: f_instr=i_inst_rdata, f_new_instr=1, f_excCode=0, f_delaySlot=d_is_jump.
//  - Kill takes precedence over fault: killed slot never reports AdEL.
//  - No latency beyond the pc register: redirect visible on i_inst_addr the cycle after the edge.
//  - Reset mid-run: pc returns to RESET_PC immediately (asynchronous), no clock edge needed.
//  - Wrap-around of pc+4 is not trapped here; range check flags the result as AdEL.
// TESTING
//  - Reset then 3 edges, no controls -> i_inst_addr 0x3000,0x3004,0x3008,0x300C; f_instr=IM data.
//  - halt=1 for 2 edges at pc 0x3010 -> pc stays 0x3010; release -> 0x3014.
//  - d_npc_sel=1,d_npc=0x3100,d_is_jump=1 at pc 0x3020 -> f_delaySlot=1 now; next pc 0x3100.
//  - d_eret=1,epc=0x3040 at pc 0x3200 -> f_new_instr=0,f_instr=0; next pc 0x3040.
//  - req=1 with halt=1 and d_eret=1 -> next pc 0x4180; d_npc=0x3002 taken -> f_excCode=4,f_instr=0.
//  - Assert reset between edges at pc 0x3050 -> f_pc=0x3000 before next edge; resumes 0x3004.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Purpose : fetch stage / F-D producer; owns the PC and drives instruction-memory address and fetch outputs.
// Latency : one pc register; redirects show on i_inst_addr the cycle after the edge, outputs are combinational.
// Backpressure: halt holds the PC (and the presented slot); req overrides halt and redirects to the handler.
//
// Ports:
//   clk, reset           clock (rising edge), asynchronous active-high reset
//   halt, req            stall from hazard unit, exception request from CP0
//   d_npc_sel, d_npc     taken branch/jump in D and its target
//   d_is_jump            D holds any branch/jump, so F holds a delay slot
//   d_eret, epc          D holds eret, and the return address from CP0
//   i_inst_rdata         instruction-memory read data for i_inst_addr
//   i_inst_addr          instruction-memory address (= pc)
//   f_pc, f_instr        PC and instruction handed to the F/D register
//   f_new_instr          1 = real instruction, 0 = bubble
//   f_excCode            0 = none, EXC_ADEL = illegal fetch address
//   f_delaySlot          fetched instruction sits in a branch delay slot
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [31:0] IM_BASE    = 32'h0000_3000,
    parameter logic [31:0] IM_LIMIT   = 32'h0000_6FFC,
    parameter logic [4:0]  EXC_ADEL   = 5'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        halt,
    input  logic        req,
    input  logic        d_npc_sel,
    input  logic [31:0] d_npc,
    input  logic        d_is_jump,
    input  logic        d_eret,
    input  logic [31:0] epc,
    input  logic [31:0] i_inst_rdata,
    output logic [31:0] i_inst_addr,
    output logic [31:0] f_pc,
    output logic [31:0] f_instr,
    output logic        f_new_instr,
    output logic [4:0]  f_excCode,
    output logic        f_delaySlot
);

    logic [31:0] pc;
    logic [31:0] pc_nxt;
    logic        addr_fault;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_nxt;
        end
    end

    // The exception request must win over a stall, otherwise a stalled
    // pipeline could never enter the handler. A stall in turn beats eret and
    // branch redirects: D is also held, so the redirect is simply re-applied
    // on the first un-stalled edge.
    always_comb begin
        pc_nxt = pc + 32'd4;
        if (req) begin
            pc_nxt = HANDLER_PC;
        end else if (halt) begin
            pc_nxt = pc;
        end else if (d_eret) begin
            pc_nxt = epc;
        end else if (d_npc_sel) begin
            pc_nxt = d_npc;
        end
    end

    // Wrap-around of pc+4 is not trapped separately; the wrapped value is
    // below IM_BASE and is reported here as AdEL.
    assign addr_fault = (pc[1:0] != 2'b00) || (pc < IM_BASE) || (pc > IM_LIMIT);

    assign i_inst_addr = pc;
    assign f_pc        = pc;

    // eret has no delay slot: the instruction behind it is squashed into a
    // bubble. A squashed slot must never raise AdEL, hence kill is checked
    // before the address fault.
    always_comb begin
        f_instr     = i_inst_rdata;
        f_new_instr = 1'b1;
        f_excCode   = 5'd0;
        f_delaySlot = d_is_jump;
        if (d_eret) begin
            f_instr     = 32'd0;
            f_new_instr = 1'b0;
            f_delaySlot = 1'b0;
        end else if (addr_fault) begin
            f_instr   = 32'd0;
            f_excCode = EXC_ADEL;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

    logic        clk;
    logic        reset;
    logic        halt;
    logic        req;
    logic        d_npc_sel;
    logic [31:0] d_npc;
    logic        d_is_jump;
    logic        d_eret;
    logic [31:0] epc;
    logic [31:0] i_inst_rdata;
    logic [31:0] i_inst_addr;
    logic [31:0] f_pc;
    logic [31:0] f_instr;
    logic        f_new_instr;
    logic [4:0]  f_excCode;
    logic        f_delaySlot;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        new_instr;
        logic [4:0]  exc;
        logic        ds;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    localparam int K_NORM  = 0;
    localparam int K_FAULT = 1;
    localparam int K_KILL  = 2;

    // Instruction memory model: distinct data per word address.
    function automatic logic [31:0] im_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h1234_0000;
    endfunction

    assign i_inst_rdata = im_word(i_inst_addr);

    if_fetch_unit dut (
        .clk          (clk),
        .reset        (reset),
        .halt         (halt),
        .req          (req),
        .d_npc_sel    (d_npc_sel),
        .d_npc        (d_npc),
        .d_is_jump    (d_is_jump),
        .d_eret       (d_eret),
        .epc          (epc),
        .i_inst_rdata (i_inst_rdata),
        .i_inst_addr  (i_inst_addr),
        .f_pc         (f_pc),
        .f_instr      (f_instr),
        .f_new_instr  (f_new_instr),
        .f_excCode    (f_excCode),
        .f_delaySlot  (f_delaySlot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic compare_out(input string tag);
        exp_t e;
        checks++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL %s scoreboard: got empty queue want one entry", tag);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            assert (i_inst_addr === e.pc) else begin
                errors++; $error("FAIL %s i_inst_addr: got %h want %h", tag, i_inst_addr, e.pc);
            end
            checks++;
            assert (f_pc === e.pc) else begin
                errors++; $error("FAIL %s f_pc: got %h want %h", tag, f_pc, e.pc);
            end
            checks++;
            assert (f_instr === e.instr) else begin
                errors++; $error("FAIL %s f_instr: got %h want %h", tag, f_instr, e.instr);
            end
            checks++;
            assert (f_new_instr === e.new_instr) else begin
                errors++; $error("FAIL %s f_new_instr: got %b want %b", tag, f_new_instr, e.new_instr);
            end
            checks++;
            assert (f_excCode === e.exc) else begin
                errors++; $error("FAIL %s f_excCode: got %0d want %0d", tag, f_excCode, e.exc);
            end
            checks++;
            assert (f_delaySlot === e.ds) else begin
                errors++; $error("FAIL %s f_delaySlot: got %b want %b", tag, f_delaySlot, e.ds);
            end
        end
    endtask

    // Push the expected F outputs for the current inputs, then sample 1 time
    // unit later (never at a rising edge) and compare.
    task automatic expect_out(input string tag, input logic [31:0] pc,
                              input int kind, input logic ds);
        exp_t e;
        e.pc = pc;
        e.ds = ds;
        case (kind)
            K_FAULT: begin e.instr = 32'd0;       e.new_instr = 1'b1; e.exc = 5'd4; end
            K_KILL:  begin e.instr = 32'd0;       e.new_instr = 1'b0; e.exc = 5'd0; e.ds = 1'b0; end
            default: begin e.instr = im_word(pc); e.new_instr = 1'b1; e.exc = 5'd0; end
        endcase
        sb.push_back(e);
        #1;
        compare_out(tag);
    endtask

    task automatic clear_ctrl();
        halt = 1'b0; req = 1'b0; d_npc_sel = 1'b0; d_npc = 32'd0;
        d_is_jump = 1'b0; d_eret = 1'b0; epc = 32'd0;
    endtask

    initial begin
        reset = 1'b1;
        clear_ctrl();
        repeat (2) @(negedge clk);
        expect_out("reset", 32'h3000, K_NORM, 1'b0);

        @(negedge clk);
        reset = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            expect_out("seq", 32'h3000 + 32'(4 * i), K_NORM, 1'b0);
        end

        // pc = 0x3010: stall for two edges, then release
        halt = 1'b1;
        @(negedge clk); expect_out("halt1", 32'h3010, K_NORM, 1'b0);
        @(negedge clk); expect_out("halt2", 32'h3010, K_NORM, 1'b0);
        halt = 1'b0;
        @(negedge clk); expect_out("unhalt", 32'h3014, K_NORM, 1'b0);
        @(negedge clk); expect_out("seq18", 32'h3018, K_NORM, 1'b0);
        @(negedge clk); expect_out("seq1c", 32'h301C, K_NORM, 1'b0);
        @(negedge clk);

        // pc = 0x3020: taken jump in D
        d_npc_sel = 1'b1; d_npc = 32'h3100; d_is_jump = 1'b1;
        expect_out("jump_ds", 32'h3020, K_NORM, 1'b1);
        @(negedge clk);
        // pc = 0x3100: halt beats a pending branch, which is retried
        halt = 1'b1; d_npc = 32'h3200;
        expect_out("halt_br", 32'h3100, K_NORM, 1'b1);
        @(negedge clk);
        halt = 1'b0;
        expect_out("br_held", 32'h3100, K_NORM, 1'b1);
        @(negedge clk);
        clear_ctrl();

        // pc = 0x3200: eret kills F and redirects to EPC
        d_eret = 1'b1; epc = 32'h3040; d_is_jump = 1'b1;
        expect_out("eret_kill", 32'h3200, K_KILL, 1'b0);
        @(negedge clk);
        clear_ctrl();
        // pc = 0x3040: req beats halt and eret
        req = 1'b1; halt = 1'b1; d_eret = 1'b1; epc = 32'h3080;
        expect_out("req_kill", 32'h3040, K_KILL, 1'b0);
        @(negedge clk);
        clear_ctrl();

        // pc = handler: jump to a misaligned target
        d_npc_sel = 1'b1; d_npc = 32'h3002; d_is_jump = 1'b1;
        expect_out("handler", 32'h4180, K_NORM, 1'b1);
        @(negedge clk);
        clear_ctrl();
        expect_out("adel_mis", 32'h3002, K_FAULT, 1'b0);
        // kill beats fault on the same slot
        d_eret = 1'b1; epc = 32'h2FFC;
        expect_out("kill_fault", 32'h3002, K_KILL, 1'b0);
        @(negedge clk);
        clear_ctrl();
        d_npc_sel = 1'b1; d_npc = 32'h6FFC;
        expect_out("adel_low", 32'h2FFC, K_FAULT, 1'b0);
        @(negedge clk);
        clear_ctrl();
        expect_out("limit_ok", 32'h6FFC, K_NORM, 1'b0);
        @(negedge clk);
        d_npc_sel = 1'b1; d_npc = 32'hFFFF_FFFC;
        expect_out("adel_high", 32'h7000, K_FAULT, 1'b0);
        @(negedge clk);
        clear_ctrl();
        expect_out("adel_top", 32'hFFFF_FFFC, K_FAULT, 1'b0);
        @(negedge clk);
        d_npc_sel = 1'b1; d_npc = 32'h3050;
        expect_out("adel_wrap", 32'h0000_0000, K_FAULT, 1'b0);
        @(negedge clk);
        clear_ctrl();

        // pc = 0x3050: asynchronous reset between edges
        expect_out("pre_rst", 32'h3050, K_NORM, 1'b0);
        #1;
        reset = 1'b1;
        expect_out("async_rst", 32'h3000, K_NORM, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        expect_out("post_rst", 32'h3004, K_NORM, 1'b0);

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL sb_drain: got %0d entries want 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
